// File: rtl/gesture_sequencer.sv
// N-channel servo gesture sequencer: pops gesture codes from a FIFO, slews PWM widths, holds each gesture.
// Optional macro GESTURE_SLEW_EN: when defined widths ramp by STEP_US per frame, otherwise they jump to target.
module gesture_sequencer #(
  parameter int NUM_CH      = 5,
  parameter int CODE_W      = 8,
  parameter int CLK_HZ      = 50000000,
  parameter int FRAME_US    = 20000,
  parameter int MIN_US      = 1000,
  parameter int MAX_US      = 2000,
  parameter int STEP_US     = 20,
  parameter int HOLD_FRAMES = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [CODE_W-1:0] cur_code,
  output logic              busy
);

  localparam int DIV = CLK_HZ / 1000000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int W   = $clog2(FRAME_US + 1);
  localparam int HW  = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
  localparam logic [W-1:0]  FRAME_LAST = W'(FRAME_US - 1);
  localparam logic [W-1:0]  MIN_W      = W'(MIN_US);
  localparam logic [W-1:0]  MAX_W      = W'(MAX_US);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);

  if (NUM_CH < 1 || NUM_CH > CODE_W || DIV < 1 || DIV * 1000000 != CLK_HZ ||
      !(MIN_US < MAX_US && MAX_US < FRAME_US) || STEP_US < 1 || HOLD_FRAMES < 1) begin : g_bad_params
    $error("gesture_sequencer: illegal parameter set");
  end

  typedef enum logic [2:0] {IDLE, POP, WAIT, MOVE, HOLD} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     pre_cnt;
  logic [W-1:0]      us_cnt;
  logic              us_tick, frame_start;
  logic [W-1:0]      width_us  [NUM_CH];
  logic [W-1:0]      width_nxt [NUM_CH];
  logic [NUM_CH-1:0] tgt_closed;
  logic              settled_nxt;
  logic [HW-1:0]     hold_cnt;
  logic              hold_clr, hold_inc, load_code;

  function automatic logic [W-1:0] target_us(input logic closed);
    return closed ? MAX_W : MIN_W;
  endfunction

`ifdef GESTURE_SLEW_EN
  localparam logic [W-1:0] STEP_W = W'(STEP_US);

  // Widths stay inside [MIN_US, MAX_US], so neither difference can wrap.
  function automatic logic [W-1:0] slew_step(input logic [W-1:0] cur, input logic [W-1:0] tgt);
    if (tgt > cur) return ((tgt - cur) <= STEP_W) ? tgt : cur + STEP_W;
    else           return ((cur - tgt) <= STEP_W) ? tgt : cur - STEP_W;
  endfunction
`endif

  // Timebase: microsecond prescaler, then frame counter
  assign us_tick     = (pre_cnt == PRE_LAST);
  assign frame_start = us_tick && (us_cnt == FRAME_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      us_cnt  <= '0;
    end else begin
      pre_cnt <= us_tick ? '0 : pre_cnt + 1'b1;
      if (us_tick) us_cnt <= frame_start ? '0 : us_cnt + 1'b1;
    end
  end

  // Width update candidates, committed only at frame_start
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef GESTURE_SLEW_EN
      width_nxt[i] = slew_step(width_us[i], target_us(tgt_closed[i]));
`else
      width_nxt[i] = target_us(tgt_closed[i]);
`endif
    end
  end

  always_comb begin
    settled_nxt = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (width_nxt[i] != target_us(tgt_closed[i])) settled_nxt = 1'b0;
  end

  // PWM output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out <= '0;
      for (int i = 0; i < NUM_CH; i++) width_us[i] <= MIN_W;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_out[i] <= (us_cnt < width_us[i]);
        if (frame_start) width_us[i] <= width_nxt[i];
      end
    end
  end

  // Sequencer: POP strobes the FIFO, WAIT catches the data one cycle later
  always_comb begin
    state_nxt = state;
    hold_clr  = 1'b0;
    hold_inc  = 1'b0;
    load_code = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) state_nxt = POP;
      POP:  state_nxt = WAIT;
      WAIT: begin
        load_code = 1'b1;
        state_nxt = MOVE;
      end
      MOVE: if (frame_start && settled_nxt) begin
        hold_clr  = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: if (frame_start) begin
        if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
        else                       hold_inc  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo_rd_en = (state == POP);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      cur_code   <= '0;
      tgt_closed <= '0;
    end else begin
      state <= state_nxt;
      if (hold_clr)      hold_cnt <= '0;
      else if (hold_inc) hold_cnt <= hold_cnt + 1'b1;
      if (load_code) begin
        cur_code   <= fifo_rd_data;
        tgt_closed <= fifo_rd_data[NUM_CH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_gesture_sequencer.sv
// Directed bench for gesture_sequencer: FIFO model, per-frame pulse-width log, cycle checkpoint and frame tables.
module tb_gesture_sequencer;

  localparam int NCH = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     fifo_rd_data;
  logic           fifo_empty;
  logic           fifo_rd_en;
  logic [NCH-1:0] pwm_out;
  logic [7:0]     cur_code;
  logic           busy;

  always #5 clk = ~clk;

  gesture_sequencer #(
    .NUM_CH(NCH), .CODE_W(8), .CLK_HZ(1000000), .FRAME_US(200),
    .MIN_US(50), .MAX_US(100), .STEP_US(10), .HOLD_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .pwm_out(pwm_out), .cur_code(cur_code), .busy(busy)
  );

`ifdef GESTURE_SLEW_EN
  localparam int T1 = 1800;
  localparam int T2 = 3200;
`else
  localparam int T1 = 1000;
  localparam int T2 = 1600;
`endif

  typedef struct { int phase; int cyc; int rd; int bsy; int code; } cp_t;
  typedef struct { int phase; int frame; int wa; int wb; } fw_t;

  cp_t cps[$];
  fw_t fws[$];

  int checks = 0, failures = 0;
  int cyc, phase, pop_n, illegal;
  int run    [NCH];
  int pw_n   [NCH];
  int pw_log [NCH][64];
  int pop_cyc[8];
  logic [7:0] fmem [16];
  int wr_p, rd_p;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (phase %0d cyc %0d)", name, act, exp, phase, cyc);
    end
  endtask

  task automatic add_cp(input int p, input int c, input int rd, input int b, input int code);
    cp_t e;
    e.phase = p; e.cyc = c; e.rd = rd; e.bsy = b; e.code = code;
    cps.push_back(e);
  endtask

  task automatic add_fw(input int p, input int f, input int wa, input int wb);
    fw_t e;
    e.phase = p; e.frame = f; e.wa = wa; e.wb = wb;
    fws.push_back(e);
  endtask

  task automatic push(input logic [7:0] code);
    fmem[wr_p % 16] = code;
    wr_p++;
    fifo_empty = 1'b0;
  endtask

  task automatic clear_logs();
    cyc = 0;
    pop_n = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      run[ch]  = 0;
      pw_n[ch] = 0;
    end
  endtask

  // One clock: sample on the falling edge, log pulses, service the FIFO, apply checkpoints.
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int ch = 0; ch < NCH; ch++) begin
      if (pwm_out[ch] === 1'b1) run[ch]++;
      else if (run[ch] > 0) begin
        if (pw_n[ch] < 64) pw_log[ch][pw_n[ch]] = run[ch];
        pw_n[ch]++;
        run[ch] = 0;
      end
    end
    if (fifo_rd_en === 1'b1) begin
      if (fifo_empty) illegal++;
      else begin
        fifo_rd_data = fmem[rd_p % 16];
        rd_p++;
      end
      if (pop_n < 8) pop_cyc[pop_n] = cyc;
      pop_n++;
    end
    fifo_empty = (rd_p == wr_p);
    for (int k = 0; k < cps.size(); k++) begin
      if (cps[k].phase == phase && cps[k].cyc == cyc) begin
        check($sformatf("rd_en@%0d", cyc), int'(fifo_rd_en), cps[k].rd);
        check($sformatf("busy@%0d", cyc), int'(busy), cps[k].bsy);
        check($sformatf("cur_code@%0d", cyc), int'(cur_code), cps[k].code);
      end
    end
  endtask

  task automatic check_frames(input int p);
    int exp, act;
    for (int k = 0; k < fws.size(); k++) begin
      if (fws[k].phase == p) begin
        for (int ch = 0; ch < NCH; ch++) begin
          exp = (ch == 0 || ch == 2) ? fws[k].wa : fws[k].wb;
          act = (pw_n[ch] > fws[k].frame) ? pw_log[ch][fws[k].frame] : -1;
          check($sformatf("p%0d frame%0d ch%0d width", p, fws[k].frame, ch), act, exp);
        end
      end
    end
  endtask

  task automatic hold_reset(input int n);
    phase = -1;
    reset = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b1;
    fifo_empty = 1'b1;
    fifo_rd_data = 8'h00;
    wr_p = 0; rd_p = 0; illegal = 0;
    clear_logs();

    // Phase 0: idle frames, then 0x05 and 0x1A back-to-back
    add_cp(0, 1, 0, 0, 8'h00);
    add_cp(0, 400, 0, 0, 8'h00);
    add_cp(0, 401, 1, 1, 8'h00);
    add_cp(0, 402, 0, 1, 8'h00);
    add_cp(0, 403, 0, 1, 8'h05);
    add_cp(0, T1 - 1, 0, 1, 8'h05);
    add_cp(0, T1,     0, 0, 8'h05);
    add_cp(0, T1 + 1, 1, 1, 8'h05);
    add_cp(0, T1 + 2, 0, 1, 8'h05);
    add_cp(0, T1 + 3, 0, 1, 8'h1A);
    add_cp(0, T2 - 1, 0, 1, 8'h1A);
    add_cp(0, T2,     0, 0, 8'h1A);
    // Phase 1: 0xE0 only touches unused bits
    add_cp(1, 10, 0, 0, 8'h00);
    add_cp(1, 11, 1, 1, 8'h00);
    add_cp(1, 13, 0, 1, 8'hE0);
    add_cp(1, 599, 0, 1, 8'hE0);
    add_cp(1, 600, 0, 0, 8'hE0);
    // Phase 2: 0x05 interrupted by reset
    add_cp(2, 11, 1, 1, 8'h00);
    add_cp(2, 13, 0, 1, 8'h05);
`ifdef GESTURE_SLEW_EN
    add_cp(2, 700, 0, 1, 8'h05);
    for (int f = 0; f < 3; f++) add_fw(0, f, 50, 50);
    add_fw(0, 3, 60, 50);  add_fw(0, 4, 70, 50);  add_fw(0, 5, 80, 50);
    add_fw(0, 6, 90, 50);  add_fw(0, 7, 100, 50); add_fw(0, 8, 100, 50);
    add_fw(0, 9, 100, 50); add_fw(0, 10, 90, 60); add_fw(0, 11, 80, 70);
    add_fw(0, 12, 70, 80); add_fw(0, 13, 60, 90);
    for (int f = 14; f < 17; f++) add_fw(0, f, 50, 100);
    add_fw(2, 0, 50, 50); add_fw(2, 1, 60, 50); add_fw(2, 2, 70, 50); add_fw(2, 3, 80, 50);
`else
    add_cp(2, 700, 0, 0, 8'h05);
    for (int f = 0; f < 3; f++)  add_fw(0, f, 50, 50);
    for (int f = 3; f < 6; f++)  add_fw(0, f, 100, 50);
    for (int f = 6; f < 17; f++) add_fw(0, f, 50, 100);
    add_fw(2, 0, 50, 50);
    for (int f = 1; f < 4; f++)  add_fw(2, f, 100, 50);
`endif
    for (int f = 0; f < 4; f++) add_fw(1, f, 50, 50);
    add_fw(3, 0, 50, 50);
    add_fw(3, 1, 50, 50);

    hold_reset(5);
    check("reset rd_en", int'(fifo_rd_en), 0);
    check("reset pwm_out", int'(pwm_out), 0);
    check("reset cur_code", int'(cur_code), 0);
    check("reset busy", int'(busy), 0);
    reset = 1'b0;
    clear_logs();

    phase = 0;
    for (int i = 0; i < 3400; i++) begin
      tick();
      if (cyc == 400) begin
        push(8'h05);
        push(8'h1A);
      end
    end
    check_frames(0);
    check("phase0 pop count", pop_n, 2);
    check("phase0 first pop cycle", pop_cyc[0], 401);
    check("phase0 second pop cycle", pop_cyc[1], T1 + 1);

    hold_reset(5);
    reset = 1'b0;
    clear_logs();
    phase = 1;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (cyc == 10) push(8'hE0);
    end
    check_frames(1);
    check("phase1 pop count", pop_n, 1);

    hold_reset(5);
    reset = 1'b0;
    clear_logs();
    phase = 2;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (cyc == 10) push(8'h05);
    end
    reset = 1'b1;
    tick();
    check("midreset pwm_out", int'(pwm_out), 0);
    check("midreset cur_code", int'(cur_code), 0);
    check("midreset busy", int'(busy), 0);
    check("midreset rd_en", int'(fifo_rd_en), 0);
    check_frames(2);
    reset = 1'b0;
    clear_logs();
    phase = 3;
    repeat (400) tick();
    check_frames(3);
    check("phase3 pop count", pop_n, 0);
    check("phase3 busy", int'(busy), 0);

    check("pop while empty", illegal, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
